lcd_hd44780_driver: RTL and testbench
=====================================

Name: lcd_hd44780_driver

Overview:
- Bus-timing engine for an HD44780-compatible character LCD (DE2-style pin set). Sits directly downstream of the Wishbone LCD register slave.
- Accepts one 9-bit LCD word (RS + 8 data bits) per valid/ready handshake.
- Generates the setup / enable-pulse / hold / execution-delay timing on the LCD pins, plus the power-up wait and optional autonomous init sequence.
- Write-only: the busy flag is never read back; timing is purely counter-based.

Parameters:
POWERUP_CYCLES, 2000000, clocks to wait after reset before the first LCD transaction (40 ms at 50 MHz)
EN_SETUP_CYCLES, 2, clocks RS/DATA are stable before EN rises (>=1)
EN_HIGH_CYCLES, 25, clocks EN is held high (>=1)
EN_HOLD_CYCLES, 2, clocks RS/DATA are held after EN falls (>=1)
CMD_DELAY_CYCLES, 2500, execution wait for normal commands and data (>=1)
LONG_DELAY_CYCLES, 82000, execution wait for clear/home commands (>=1)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_valid  in  1  upstream word valid
o_ready  out  1  driver idle; a word is accepted when i_valid && o_ready
i_rs  in  1  register select of the offered word (0 = command, 1 = data)
i_data  in  8  data byte of the offered word
o_busy  out  1  high whenever the state is not IDLE
o_disp_data  out  8  LCD DB[7:0]
o_disp_rw  out  1  LCD R/W; constant 0 (write)
o_disp_en  out  1  LCD E strobe, active high
o_disp_rs  out  1  LCD RS
o_disp_on_n  out  1  LCD power enable, active low
o_disp_blon  out  1  backlight enable

Behaviour:
- Clock and reset: clock i_clk; reset i_reset, synchronous, active-high.
- All outputs are registered. 32-bit down-counter. States: PWRUP, INIT, SETUP, PULSE, HOLD, DELAY, IDLE.
- Reset values:
  - state PWRUP, counter = POWERUP_CYCLES
  - o_disp_data 0, o_disp_rs 0, o_disp_en 0, o_disp_rw 0, o_disp_on_n 0, o_disp_blon 1
  - o_ready 0, o_busy 1
- PWRUP: counts POWERUP_CYCLES clocks, then goes to INIT (macro on) or IDLE (macro off).
- IDLE:
  - o_ready = 1, o_busy = 0.
  - On i_valid, latch i_rs/i_data into o_disp_rs/o_disp_data and enter SETUP.
  - i_rs/i_data are ignored whenever o_ready = 0.
- SETUP: EN_SETUP_CYCLES clocks, EN = 0.
- PULSE: EN_HIGH_CYCLES clocks with o_disp_en = 1.
- HOLD: EN_HOLD_CYCLES clocks, EN = 0, RS/DATA unchanged.
- DELAY:
  - Lasts LONG_DELAY_CYCLES when the word is a clear/home command (rs == 0 and data[7:2] == 0 and data[1:0] != 0, i.e. 0x01/0x02/0x03).
  - Lasts CMD_DELAY_CYCLES for all other words.
  - Then returns to IDLE, or to INIT if init words remain.
- Throughput:
  - Busy time per word = EN_SETUP + EN_HIGH + EN_HOLD + delay clocks.
  - o_ready is high on the very next clock after DELAY expires.
  - Back-to-back words are accepted on the first IDLE cycle.
- o_disp_data/o_disp_rs change only when a word is latched (accept or INIT load). They are stable from SETUP through DELAY.
- o_disp_on_n stays 0 and o_disp_blon stays 1 at all times after reset.
- Reset mid-operation:
  - The next edge forces the reset values: EN drops to 0 and the pending word is discarded.
  - Power-up wait restarts.
- A zero-valued parameter is illegal; behaviour with zero values is not defined.

Optional Feature:
LCD_INIT_SEQ_EN
- Defined:
  - After PWRUP, INIT issues the fixed ROM words in order, all rs = 0: 0x38, 0x0C, 0x01, 0x06.
  - Each word uses the full SETUP/PULSE/HOLD/DELAY timing; 0x01 takes the long delay.
  - o_ready stays 0 until the last word's DELAY completes.
- Undefined:
  - No INIT state and no ROM; PWRUP goes directly to IDLE.
  - Software must send the init words.

Test Plan:
Bench parameters for all scenarios: POWERUP=10, SETUP=2, HIGH=4, HOLD=2, CMD=8, LONG=20.
1. Reset, no macro -> all outputs at reset values (blon = 1, on_n = 0, en = 0, ready = 0). o_ready rises exactly 10 clocks after reset release.
2. Macro defined, reset released -> four EN pulses, each exactly 4 clocks high, rs = 0, data 0x38 / 0x0C / 0x01 / 0x06. Spacing 16 clocks after 0x38 and 0x0C, 28 clocks after 0x01. o_ready rises 16 clocks after the 0x06 accept point.
3. Data word rs = 1, data 0x41 accepted -> o_disp_rs = 1 and o_disp_data = 0x41 next clock. EN high on clocks 3–6 after accept. o_ready back 16 clocks after accept.
4. Commands: rs = 0, 0x01 -> 28 busy clocks; rs = 0, 0x02 -> 28; rs = 1, 0x01 -> 16; rs = 0, 0x80 -> 16.
5. i_valid held high with the word changed every clock -> only the words present on ready cycles are emitted. The second word is accepted exactly on the first ready clock.
6. i_reset asserted during PULSE -> o_disp_en = 0 on the next clock, o_ready = 0. The 10-clock power-up wait restarts, and the interrupted word is never re-issued.

Source files
------------

// File: rtl/lcd_hd44780_driver_if.sv
// Word handshake between the LCD register slave and the HD44780 timing engine.
// The member names follow the driver's established port names.
interface lcd_hd44780_driver_if;
  logic       i_valid;
  logic       o_ready;
  logic       i_rs;
  logic [7:0] i_data;

  modport master (
    output i_valid,
    output i_rs,
    output i_data,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_rs,
    input  i_data,
    output o_ready
  );
endinterface

// File: rtl/lcd_hd44780_driver.sv
// HD44780 bus-timing engine: power-up wait, then per-word setup/E-pulse/hold/exec delay.
// Define LCD_INIT_SEQ_EN to issue the 0x38/0x0C/0x01/0x06 init words autonomously.
module lcd_hd44780_driver #(
  parameter int unsigned POWERUP_CYCLES    = 2000000,
  parameter int unsigned EN_SETUP_CYCLES   = 2,
  parameter int unsigned EN_HIGH_CYCLES    = 25,
  parameter int unsigned EN_HOLD_CYCLES    = 2,
  parameter int unsigned CMD_DELAY_CYCLES  = 2500,
  parameter int unsigned LONG_DELAY_CYCLES = 82000
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  lcd_hd44780_driver_if.slave         up,
  output logic                        o_busy,
  output logic [7:0]                  o_disp_data,
  output logic                        o_disp_rw,
  output logic                        o_disp_en,
  output logic                        o_disp_rs,
  output logic                        o_disp_on_n,
  output logic                        o_disp_blon
);

  localparam logic [31:0] PWR_C   = 32'(POWERUP_CYCLES);
  localparam logic [31:0] SETUP_C = 32'(EN_SETUP_CYCLES);
  localparam logic [31:0] HIGH_C  = 32'(EN_HIGH_CYCLES);
  localparam logic [31:0] HOLD_C  = 32'(EN_HOLD_CYCLES);
  localparam logic [31:0] CMD_C   = 32'(CMD_DELAY_CYCLES);
  localparam logic [31:0] LONG_C  = 32'(LONG_DELAY_CYCLES);

  typedef enum logic [2:0] {
    PWRUP,
    SETUP,
    PULSE,
    HOLD,
    DELAY,
    IDLE
`ifdef LCD_INIT_SEQ_EN
    , INIT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        rs_d;
  logic [7:0]  data_d;
  logic        is_long;

`ifdef LCD_INIT_SEQ_EN
  logic [2:0]  idx_q, idx_d;

  function automatic logic [7:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    init_word = 8'h38;
      3'd1:    init_word = 8'h0C;
      3'd2:    init_word = 8'h01;
      3'd3:    init_word = 8'h06;
      default: init_word = 8'h00;
    endcase
  endfunction
`endif

  // Clear (0x01) and home (0x02/0x03) need the long execution time.
  assign is_long = !o_disp_rs && (o_disp_data[7:2] == 6'd0) && (o_disp_data[1:0] != 2'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = o_disp_rs;
    data_d  = o_disp_data;
`ifdef LCD_INIT_SEQ_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      PWRUP: begin
        if (cnt_q <= 32'd1) begin
`ifdef LCD_INIT_SEQ_EN
          state_d = INIT;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
`ifdef LCD_INIT_SEQ_EN
      INIT: begin
        rs_d    = 1'b0;
        data_d  = init_word(idx_q);
        idx_d   = idx_q + 3'd1;
        state_d = SETUP;
        cnt_d   = SETUP_C;
      end
`endif
      IDLE: begin
        if (up.i_valid) begin
          rs_d    = up.i_rs;
          data_d  = up.i_data;
          state_d = SETUP;
          cnt_d   = SETUP_C;
        end
      end
      SETUP: begin
        if (cnt_q <= 32'd1) begin
          state_d = PULSE;
          cnt_d   = HIGH_C;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      PULSE: begin
        if (cnt_q <= 32'd1) begin
          state_d = HOLD;
          cnt_d   = HOLD_C;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      HOLD: begin
        if (cnt_q <= 32'd1) begin
          state_d = DELAY;
          cnt_d   = is_long ? LONG_C : CMD_C;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      DELAY: begin
        if (cnt_q <= 32'd1) begin
`ifdef LCD_INIT_SEQ_EN
          // Remaining init words load straight into SETUP so spacing matches host words.
          if (idx_q < 3'd4) begin
            rs_d    = 1'b0;
            data_d  = init_word(idx_q);
            idx_d   = idx_q + 3'd1;
            state_d = SETUP;
            cnt_d   = SETUP_C;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = PWRUP;
        cnt_d   = PWR_C;
      end
    endcase
  end

  // Strobes and handshake outputs are registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= PWRUP;
      cnt_q       <= PWR_C;
      o_disp_data <= '0;
      o_disp_rs   <= 1'b0;
      o_disp_en   <= 1'b0;
      o_disp_rw   <= 1'b0;
      o_disp_on_n <= 1'b0;
      o_disp_blon <= 1'b1;
      up.o_ready  <= 1'b0;
      o_busy      <= 1'b1;
`ifdef LCD_INIT_SEQ_EN
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      o_disp_data <= data_d;
      o_disp_rs   <= rs_d;
      o_disp_en   <= (state_d == PULSE);
      o_disp_rw   <= 1'b0;
      o_disp_on_n <= 1'b0;
      o_disp_blon <= 1'b1;
      up.o_ready  <= (state_d == IDLE);
      o_busy      <= (state_d != IDLE);
`ifdef LCD_INIT_SEQ_EN
      idx_q       <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Directed bench for lcd_hd44780_driver: power-up, word timing table, back-to-back, reset mid-pulse.
module tb_lcd_hd44780_driver;

`ifdef LCD_INIT_SEQ_EN
  localparam int EXP_READY = 87;
`else
  localparam int EXP_READY = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [7:0] disp_data;
  logic       disp_rw, disp_en, disp_rs, disp_on_n, disp_blon;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_hd44780_driver_if bus ();

  lcd_hd44780_driver #(
    .POWERUP_CYCLES   (10),
    .EN_SETUP_CYCLES  (2),
    .EN_HIGH_CYCLES   (4),
    .EN_HOLD_CYCLES   (2),
    .CMD_DELAY_CYCLES (8),
    .LONG_DELAY_CYCLES(20)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .up         (bus),
    .o_busy     (busy),
    .o_disp_data(disp_data),
    .o_disp_rw  (disp_rw),
    .o_disp_en  (disp_en),
    .o_disp_rs  (disp_rs),
    .o_disp_on_n(disp_on_n),
    .o_disp_blon(disp_blon)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         busy_clks;
  } vec_t;

  vec_t tv[8];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    step;
    chk("rst_en", disp_en, 1'b0);
    chk("rst_ready", bus.o_ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_blon", disp_blon, 1'b1);
    chk("rst_on_n", disp_on_n, 1'b0);
    chk("rst_rw", disp_rw, 1'b0);
    chk("rst_data", disp_data, 8'h00);
    chk("rst_rs", disp_rs, 1'b0);
    step;
    rst = 1'b0;
  endtask

  task automatic powerup;
    int n = 0;
    int w = 0;
    logic prev_en = 1'b0;
    int rise[$];
    int width[$];
    logic [7:0] dq[$];
    logic rq[$];
`ifdef LCD_INIT_SEQ_EN
    logic [7:0] exp_w[4];
    int exp_sp[3];
    exp_w = '{8'h38, 8'h0C, 8'h01, 8'h06};
    exp_sp = '{16, 16, 28};
`endif
    while (!bus.o_ready && n < 300) begin
      step;
      n++;
      if (disp_en && !prev_en) begin
        rise.push_back(n);
        dq.push_back(disp_data);
        rq.push_back(disp_rs);
        w = 0;
      end
      if (disp_en) w++;
      if (!disp_en && prev_en) width.push_back(w);
      prev_en = disp_en;
    end
    chk("pwrup_ready_latency", n, EXP_READY);
    chk("pwrup_blon", disp_blon, 1'b1);
    chk("pwrup_on_n", disp_on_n, 1'b0);
`ifdef LCD_INIT_SEQ_EN
    chk("init_pulses", rise.size(), 4);
    chk("init_widths", width.size(), 4);
    if (rise.size() == 4 && width.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("init_data", dq[i], exp_w[i]);
        chk("init_rs", rq[i], 1'b0);
        chk("init_en_width", width[i], 4);
      end
      for (int i = 0; i < 3; i++) chk("init_spacing", rise[i+1] - rise[i], exp_sp[i]);
      chk("init_ready_after_last", n - (rise[3] - 2), 16);
    end
`else
    chk("pwrup_no_pulses", rise.size(), 0);
`endif
  endtask

  initial begin
    int k, first, last, npulse;
    logic stable;

    tv[0] = '{rs: 1'b1, data: 8'h41, busy_clks: 16};
    tv[1] = '{rs: 1'b0, data: 8'h01, busy_clks: 28};
    tv[2] = '{rs: 1'b0, data: 8'h02, busy_clks: 28};
    tv[3] = '{rs: 1'b1, data: 8'h01, busy_clks: 16};
    tv[4] = '{rs: 1'b0, data: 8'h80, busy_clks: 16};
    tv[5] = '{rs: 1'b0, data: 8'h03, busy_clks: 28};
    tv[6] = '{rs: 1'b0, data: 8'h04, busy_clks: 16};
    tv[7] = '{rs: 1'b0, data: 8'h00, busy_clks: 16};

    bus.i_valid = 1'b0;
    bus.i_rs    = 1'b0;
    bus.i_data  = 8'h00;

    apply_reset;
    powerup;

    // Single-word timing table
    for (int v = 0; v < 8; v++) begin
      chk("idle_ready", bus.o_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
      bus.i_valid = 1'b1;
      bus.i_rs    = tv[v].rs;
      bus.i_data  = tv[v].data;
      step;
      bus.i_valid = 1'b0;
      bus.i_rs    = ~tv[v].rs;
      bus.i_data  = ~tv[v].data;
      chk("latch_rs", disp_rs, tv[v].rs);
      chk("latch_data", disp_data, tv[v].data);
      chk("accept_ready_low", bus.o_ready, 1'b0);
      k = 0; first = -1; last = -1; npulse = 0; stable = 1'b1;
      while (k < 100) begin
        if (bus.o_ready) break;
        if (disp_en) begin
          if (first < 0) first = k;
          last = k;
          npulse++;
        end
        if (disp_data !== tv[v].data || disp_rs !== tv[v].rs) stable = 1'b0;
        step;
        k++;
      end
      chk("busy_clocks", k, tv[v].busy_clks);
      chk("en_first", first, 2);
      chk("en_last", last, 5);
      chk("en_count", npulse, 4);
      chk("word_stable", stable, 1'b1);
    end

    // Back-to-back with i_valid held and word changing every clock
    for (int i = 0; i < 18; i++) begin
      bus.i_valid = 1'b1;
      bus.i_rs    = 1'b1;
      bus.i_data  = 8'(32'h50 + i);
      step;
      if (i == 0) chk("b2b_first_word", disp_data, 8'h50);
      if (i == 15) chk("b2b_not_ready_yet", bus.o_ready, 1'b0);
      if (i == 16) begin
        chk("b2b_ready_edge", bus.o_ready, 1'b1);
        chk("b2b_held_word", disp_data, 8'h50);
      end
      if (i == 17) begin
        chk("b2b_second_word", disp_data, 8'h61);
        chk("b2b_second_ready", bus.o_ready, 1'b0);
      end
    end
    bus.i_valid = 1'b0;
    k = 0;
    while (!bus.o_ready && k < 100) begin
      step;
      k++;
    end
    chk("b2b_second_busy", k, 16);
    chk("b2b_second_kept", disp_data, 8'h61);

    // Reset during the E pulse
    bus.i_valid = 1'b1;
    bus.i_rs    = 1'b1;
    bus.i_data  = 8'h5A;
    step;
    bus.i_valid = 1'b0;
    k = 0;
    while (!disp_en && k < 20) begin
      step;
      k++;
    end
    chk("midpulse_reached", disp_en, 1'b1);
    step;
    apply_reset;
    powerup;
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      step;
      if (disp_en) npulse++;
    end
    chk("no_reissue", npulse, 0);
    chk("no_reissue_ready", bus.o_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
